lfsr_parity_checker: RTL
========================

# lfsr_parity_checker

Downstream consumer of the LFSR/parity generator output. Accepts one 8-bit word per valid cycle: payload in bits [6:0], even-parity bit in bit [7]. Checks parity on every word. Synchronises a local 7-bit LFSR predictor to the incoming stream, then flags sequence errors and keeps saturating statistics counters for the bring-up logic.

## Interface
Reset is asynchronous and active-low.

**Parameters**
- LOCK_COUNT, 4: consecutive good words (seed included) needed to declare lock; legal range 2..15.
- LOSS_COUNT, 3: consecutive sequence mismatches in LOCKED that drop lock; legal range 1..15.
- CNT_W, 16: width of each statistics counter.

**Ports**
- clk, input, 1: single clock, all state rising-edge.
- rst_n, input, 1: asynchronous active-low reset.
- ena, input, 1: block enable. When low, all state holds and pulse outputs are 0.
- in_valid, input, 1: in_data carries a word this cycle.
- in_data, input, 8: [6:0] LFSR payload, [7] parity bit.
- clear, input, 1: synchronous clear of the three counters only.
- locked, output, 1: high while the FSM is in LOCKED.
- state, output, 2: 0 HUNT, 1 CHECK, 2 LOCKED.
- parity_err, output, 1: one-cycle pulse for a word with bad parity.
- seq_err, output, 1: one-cycle pulse for a LOCKED-state payload mismatch.
- word_cnt, output, CNT_W: count of accepted words.
- perr_cnt, output, CNT_W: count of parity errors.
- serr_cnt, output, CNT_W: count of sequence errors.

## Operation
- A word is accepted when ena=1 and in_valid=1. Nothing else changes state.
- Parity is good when the XOR of all 8 bits of in_data is 0 (bit7 = ^payload).
- LFSR step: next(s) = {s[5:0], s[6]^s[5]} (x^7+x^6+1, maximal, period 127). Payload 0 is the lock-up state and is never valid.
- FSM states:
  - **HUNT:** accepted word with good parity and nonzero payload → pred=next(payload), mcnt=1, go to CHECK. Any other word stays in HUNT.
  - **CHECK:** accepted word with good parity and payload==pred → mcnt++, pred=next(payload). If mcnt reaches LOCK_COUNT, go to LOCKED with miss=0. Any other word is discarded, go to HUNT. seq_err is not raised in CHECK.
  - **LOCKED:** on each accepted word, compare payload to pred (parity ignored for the compare). pred=next(pred) either way (flywheel).
    - Match: miss=0.
    - Mismatch: seq_err pulse, serr_cnt++, miss++. If miss reaches LOSS_COUNT, go to HUNT.
- parity_err pulse and perr_cnt++ on any accepted word with bad parity, in every state.
- word_cnt++ on every accepted word.
- Counters saturate at all-ones with no wrap.
- clear=1 zeroes all three counters. clear wins over a same-cycle increment. FSM, pred, mcnt and miss are unaffected.
- Reset values: state=HUNT, locked=0, parity_err=0, seq_err=0, all counters 0, pred=0, mcnt=0, miss=0.
- rst_n asserted mid-stream forces the reset values immediately (asynchronous). The first accepted word after release is treated as a HUNT candidate.

## Timing
- All outputs are registered. A word accepted at edge k updates flags, counters, state and locked at edge k, visible during cycle k..k+1.
- Pulses are exactly one cycle wide. Back-to-back bad words give back-to-back pulses.
- Back-to-back accepted words are supported every cycle, with no stall and no ready signal.
- A word with both bad parity and a sequence mismatch in LOCKED raises both pulses in the same cycle and increments both counters.
- Latency from seed word to locked=1 is LOCK_COUNT accepted words. locked rises on the edge accepting the LOCK_COUNT-th word.

## Test plan
- **Lock:** defaults, reset, stream 0x81,0x82,0x84,0x88 on consecutive cycles → locked=1 after the 4th edge; word_cnt=4, perr_cnt=0, serr_cnt=0.
- **Parity error in CHECK:** stream 0x81,0x02 (bad parity) → parity_err pulse on the 2nd word, perr_cnt=1, state back to HUNT; then 0x84,0x88,0x90,0xA0 → locked after 0xA0.
- **Loss of lock:** lock on 0x81..0x88, then send 0x55, 0x55, 0x55 → seq_err pulse on each, serr_cnt=3, state=HUNT after the 3rd.
- **Flywheel:** lock on 0x81..0x88, send 0x55, then 0x20 (the correct next-next payload) → one seq_err, miss reset, locked stays 1.
- **Lock-up and gaps:** words 0x00 repeatedly → stays HUNT with no parity_err. ena=0 or in_valid=0 cycles inserted mid-stream → counters and state unchanged.
- **Counters:** CNT_W=3, feed 9 bad-parity words → perr_cnt saturates at 7. clear asserted with an accepted bad word → perr_cnt=0. rst_n pulled low mid-LOCKED → locked drops at once, counters=0.

Source files
------------

// File: rtl/lfsr_parity_checker.sv
// lfsr_parity_checker
//   Consumer side of the LFSR/parity stream. Every accepted word (ena & in_valid)
//   is checked for even parity over all 8 bits. A local x^7+x^6+1 predictor is
//   seeded from the stream. After LOCK_COUNT consecutive good words the block
//   declares lock. In LOCKED it flags payload mismatches and drops lock after
//   LOSS_COUNT consecutive misses. It also keeps three saturating statistics
//   counters.
//
// Ports
//   clk, rst_n         : clock, asynchronous active-low reset
//   ena                : block enable; low holds all state and zeroes pulses
//   in_valid, in_data  : word strobe; in_data[6:0] payload, in_data[7] parity
//   clear              : synchronous clear of the three counters
//   locked, state      : lock flag and FSM state (0 HUNT, 1 CHECK, 2 LOCKED)
//   parity_err         : one-cycle pulse, accepted word with bad parity
//   seq_err            : one-cycle pulse, LOCKED payload mismatch
//   word_cnt, perr_cnt, serr_cnt : saturating statistics counters
module lfsr_parity_checker #(
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned LOSS_COUNT = 3,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             clear,
   output logic             locked,
   output logic [1:0]       state,
   output logic             parity_err,
   output logic             seq_err,
   output logic [CNT_W-1:0] word_cnt,
   output logic [CNT_W-1:0] perr_cnt,
   output logic [CNT_W-1:0] serr_cnt
);

   typedef enum logic [1:0] {
      StHunt   = 2'd0,
      StCheck  = 2'd1,
      StLocked = 2'd2
   } state_e;

   localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);
   localparam logic [3:0] LossCnt = 4'(LOSS_COUNT);

   function automatic logic [6:0] lfsr_next(input logic [6:0] s);
      return {s[5:0], s[6] ^ s[5]};
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == '1) ? c : c + 1'b1;
   endfunction

   state_e           state_q, state_d;
   logic [6:0]       pred_q, pred_d;
   logic [3:0]       mcnt_q, mcnt_d;
   logic [3:0]       miss_q, miss_d;
   logic             locked_q, locked_d;
   logic             perr_q, perr_d;
   logic             serr_q, serr_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0] perr_cnt_q, perr_cnt_d;
   logic [CNT_W-1:0] serr_cnt_q, serr_cnt_d;

   logic       accept;
   logic       parity_ok;
   logic [6:0] payload;
   logic [3:0] mcnt_inc;
   logic [3:0] miss_inc;

   assign accept    = ena & in_valid;
   assign parity_ok = ~(^in_data);
   assign payload   = in_data[6:0];
   assign mcnt_inc  = mcnt_q + 4'd1;
   assign miss_inc  = miss_q + 4'd1;

   // FSM, predictor and pulse next-state
   always_comb begin
      state_d = state_q;
      pred_d  = pred_q;
      mcnt_d  = mcnt_q;
      miss_d  = miss_q;
      perr_d  = 1'b0;
      serr_d  = 1'b0;
      if (accept) begin
         perr_d = ~parity_ok;
         case (state_q)
            StHunt: begin
               // Payload 0 is the LFSR lock-up state and can never seed
               if (parity_ok && (payload != 7'd0)) begin
                  pred_d  = lfsr_next(payload);
                  mcnt_d  = 4'd1;
                  state_d = StCheck;
               end
            end
            StCheck: begin
               if (parity_ok && (payload == pred_q)) begin
                  mcnt_d = mcnt_inc;
                  pred_d = lfsr_next(payload);
                  if (mcnt_inc == LockCnt) begin
                     state_d = StLocked;
                     miss_d  = 4'd0;
                  end
               end else begin
                  state_d = StHunt;
                  mcnt_d  = 4'd0;
               end
            end
            StLocked: begin
               // Flywheel: predictor free-runs regardless of the received payload
               pred_d = lfsr_next(pred_q);
               if (payload == pred_q) begin
                  miss_d = 4'd0;
               end else begin
                  serr_d = 1'b1;
                  miss_d = miss_inc;
                  if (miss_inc == LossCnt) begin
                     state_d = StHunt;
                  end
               end
            end
            default: state_d = StHunt;
         endcase
      end
      locked_d = (state_d == StLocked);
   end

   // Counters: clear beats a same-cycle increment; all hold while ena is low
   always_comb begin
      word_cnt_d = word_cnt_q;
      perr_cnt_d = perr_cnt_q;
      serr_cnt_d = serr_cnt_q;
      if (ena) begin
         if (clear) begin
            word_cnt_d = '0;
            perr_cnt_d = '0;
            serr_cnt_d = '0;
         end else if (accept) begin
            word_cnt_d = sat_inc(word_cnt_q);
            if (perr_d) perr_cnt_d = sat_inc(perr_cnt_q);
            if (serr_d) serr_cnt_d = sat_inc(serr_cnt_q);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StHunt;
         pred_q     <= 7'd0;
         mcnt_q     <= 4'd0;
         miss_q     <= 4'd0;
         locked_q   <= 1'b0;
         perr_q     <= 1'b0;
         serr_q     <= 1'b0;
         word_cnt_q <= '0;
         perr_cnt_q <= '0;
         serr_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         pred_q     <= pred_d;
         mcnt_q     <= mcnt_d;
         miss_q     <= miss_d;
         locked_q   <= locked_d;
         perr_q     <= perr_d;
         serr_q     <= serr_d;
         word_cnt_q <= word_cnt_d;
         perr_cnt_q <= perr_cnt_d;
         serr_cnt_q <= serr_cnt_d;
      end
   end

   assign locked     = locked_q;
   assign state      = state_q;
   assign parity_err = perr_q;
   assign seq_err    = serr_q;
   assign word_cnt   = word_cnt_q;
   assign perr_cnt   = perr_cnt_q;
   assign serr_cnt   = serr_cnt_q;

endmodule
